// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the I/D main-memory arbiter.
package mem_arb_pkg;
    localparam int DEF_ADDR_W = 28;
    localparam int DEF_DATA_W = 128;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT_I = 2'd1,
        S_GNT_D = 2'd2,
        S_GAP   = 2'd3
    } state_t;
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational I/D grant select.
// MEM_ARB_RR_EN selects round-robin on contention; otherwise D always wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
`ifdef MEM_ARB_RR_EN
    input  logic last_gnt,
`endif
    output logic any_req,
    output logic gnt
);
    assign any_req = i_req | d_req;
`ifdef MEM_ARB_RR_EN
    assign gnt = (i_req && d_req) ? ~last_gnt : (d_req ? GNT_D : GNT_I);
`else
    assign gnt = d_req ? GNT_D : GNT_I;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 128-bit memory port between I-cache and D-cache.
// MEM_ARB_RR_EN enables round-robin on simultaneous requests (default: fixed D priority).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    state_t state_q, state_d;
    logic   any_req, gnt, gnt_i, gnt_d;
`ifdef MEM_ARB_RR_EN
    logic   last_gnt_q, last_gnt_d;
`endif

    mem_arb_pick u_pick (
        .i_req    (i_read | i_write),
        .d_req    (d_read | d_write),
`ifdef MEM_ARB_RR_EN
        .last_gnt (last_gnt_q),
`endif
        .any_req  (any_req),
        .gnt      (gnt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = any_req ? (gnt == GNT_D ? S_GNT_D : S_GNT_I) : S_IDLE;
            S_GNT_I,
            S_GNT_D: state_d = mem_ready ? S_GAP : state_q;
            default: state_d = S_IDLE;
        endcase
`ifdef MEM_ARB_RR_EN
        last_gnt_d = (state_q == S_IDLE && any_req) ? gnt : last_gnt_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q <= S_IDLE;
`ifdef MEM_ARB_RR_EN
            last_gnt_q <= GNT_D;
`endif
        end else begin
            state_q <= state_d;
`ifdef MEM_ARB_RR_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

    // Request lines follow the owner live, so a dropped request goes low at memory too.
    assign gnt_i     = state_q == S_GNT_I;
    assign gnt_d     = state_q == S_GNT_D;
    assign mem_read  = (gnt_i & i_read) | (gnt_d & d_read);
    assign mem_write = (gnt_i & i_write) | (gnt_d & d_write);
    assign mem_addr  = gnt_i ? i_addr : gnt_d ? d_addr : '0;
    assign mem_wdata = gnt_i ? i_wdata : gnt_d ? d_wdata : '0;
    assign i_ready   = gnt_i & mem_ready;
    assign d_ready   = gnt_d & mem_ready;
    assign i_rdata   = gnt_i ? mem_rdata : '0;
    assign d_rdata   = gnt_d ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;
    localparam int ADDR_W = DEF_ADDR_W;
    localparam int DATA_W = DEF_DATA_W;
    localparam int CW = 2 + ADDR_W + 3 * DATA_W + 2;

    logic clk = 1'b0;
    logic proc_reset, i_read, i_write, d_read, d_write, i_ready, d_ready;
    logic mem_read, mem_write, mem_ready;
    logic [ADDR_W-1:0] i_addr, d_addr, mem_addr;
    logic [DATA_W-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;

    // Model: owner 0 = nobody, 1 = I, 2 = D; new grants allowed from edge idle_from on.
    int passed = 0, total = 0, cyc = 0, idle_from = 0, owner = 0, lat = 0;
    bit done_i, done_d;
`ifdef MEM_ARB_RR_EN
    bit last_d = 1'b1;
`endif
    logic [ADDR_W-1:0] prev_addr;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .proc_reset(proc_reset),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic chk(string tag, logic [CW-1:0] obs, logic [CW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic mid(string tag);
        logic gi, gd;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ew, ei, ed;
        #4;
        gi = owner == 1;
        gd = owner == 2;
        ea = gi ? i_addr : gd ? d_addr : '0;
        ew = gi ? i_wdata : gd ? d_wdata : '0;
        ei = gi ? mem_rdata : '0;
        ed = gd ? mem_rdata : '0;
        chk(tag, {mem_read, mem_write, mem_addr, mem_wdata, i_ready, d_ready, i_rdata, d_rdata},
            {(gi & i_read) | (gd & d_read), (gi & i_write) | (gd & d_write), ea, ew,
             gi & mem_ready, gd & mem_ready, ei, ed});
    endtask

    task automatic tick();
        bit ireq, dreq;
        @(posedge clk);
        ireq = i_read | i_write;
        dreq = d_read | d_write;
        done_i = !proc_reset && owner == 1 && mem_ready;
        done_d = !proc_reset && owner == 2 && mem_ready;
        if (proc_reset) begin
            owner = 0;
            idle_from = cyc + 1;
`ifdef MEM_ARB_RR_EN
            last_d = 1'b1;
`endif
        end else if (owner != 0) begin
            if (mem_ready) begin
                owner = 0;
                idle_from = cyc + 2;
            end
        end else if (cyc >= idle_from && (ireq || dreq)) begin
`ifdef MEM_ARB_RR_EN
            owner = (ireq && dreq) ? (last_d ? 1 : 2) : (dreq ? 2 : 1);
            last_d = owner == 2;
`else
            owner = dreq ? 2 : 1;
`endif
        end
        cyc++;
        #1;
    endtask

    initial begin
        proc_reset = 1'b1;
        {i_read, i_write, d_read, d_write, mem_ready} = '0;
        {i_addr, d_addr} = '0;
        {i_wdata, d_wdata, mem_rdata} = '0;
        tick();
        mid("reset");
        chk("reset_idle", CW'({mem_read, mem_write, i_ready, d_ready}), CW'(0));
        tick();
        // Reset in the middle of a D grant, with a stray ready right after.
        proc_reset = 1'b0;
        d_read = 1'b1;
        d_addr = 28'h0000010;
        mid("t1_req");
        tick();
        mid("t1_gnt");
        chk("t1_mem_read", CW'(mem_read), CW'(1));
        chk("t1_mem_addr", CW'(mem_addr), CW'(28'h10));
        tick();
        proc_reset = 1'b1;
        mid("t1_hold");
        tick();
        proc_reset = 1'b0;
        mem_ready = 1'b1;
        mid("t1_after_rst");
        chk("t1_rst_read_ready", CW'({mem_read, d_ready, i_ready}), CW'(0));
        d_read = 1'b0;
        tick();
        mem_ready = 1'b0;
        mid("t5_idle");
        chk("t5_stray_ignored", CW'({mem_read, mem_write}), CW'(0));
        tick();
        // Single I read.
        i_read = 1'b1;
        i_addr = 28'h0000004;
        mid("t2_req");
        chk("t2_not_yet", CW'(mem_read), CW'(0));
        tick();
        mid("t2_gnt");
        chk("t2_mem_read_addr", CW'({mem_read, mem_addr}), CW'({1'b1, 28'h4}));
        tick();
        repeat (3) begin
            mid("t2_wait");
            tick();
        end
        mem_ready = 1'b1;
        mem_rdata = {16{8'hA5}};
        mid("t2_ready");
        chk("t2_i_ready_rdata", CW'({i_ready, d_ready, i_rdata}), CW'({2'b10, {16{8'hA5}}}));
        tick();
        mem_ready = 1'b0;
        i_read = 1'b0;
        mid("t2_gap");
        chk("t2_gap_read", CW'({mem_read, i_ready}), CW'(0));
        tick();
        mid("t2_idle");
        tick();
        // Contention: D first, I waits out the gap; I bus noise must not leak.
        i_read = 1'b1;
        d_write = 1'b1;
        d_addr = 28'h0000008;
        d_wdata = 128'h1;
        mid("t3_req");
        tick();
        repeat (2) begin
            i_addr = ADDR_W'($urandom);
            i_wdata = {$urandom, $urandom, $urandom, $urandom};
            mid("t6_iso");
            chk("t6_d_owns_bus", CW'({mem_write, mem_addr, mem_wdata, i_ready}),
                CW'({1'b1, 28'h8, 128'h1, 1'b0}));
            tick();
        end
        mem_ready = 1'b1;
        mid("t3_d_ready");
        chk("t3_d_ready_only", CW'({d_ready, i_ready}), CW'(2'b10));
        tick();
        mem_ready = 1'b0;
        d_write = 1'b0;
        i_addr = 28'h0000004;
        mid("t3_gap");
        chk("t3_gap_quiet", CW'({mem_read, mem_write, i_ready}), CW'(0));
        tick();
        mid("t3_idle");
        chk("t3_idle_quiet", CW'({mem_read, i_ready}), CW'(0));
        tick();
        mem_ready = 1'b1;
        mid("t3_i_ready");
        chk("t3_i_served", CW'({mem_read, mem_addr, i_ready}), CW'({1'b1, 28'h4, 1'b1}));
        tick();
        mem_ready = 1'b0;
        i_read = 1'b0;
        mid("t3_end");
        tick();
        // Both caches request continuously for four transactions.
        i_read = 1'b1;
        d_read = 1'b1;
        i_addr = 28'h1;
        d_addr = 28'h2;
        prev_addr = 28'h1;
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 6; k++) begin
                mid("t4_wait");
                if (mem_read) break;
                tick();
            end
            chk("t4_granted", CW'(mem_read), CW'(1));
`ifdef MEM_ARB_RR_EN
            chk("t4_alternate", CW'(mem_addr), CW'(prev_addr == 28'h1 ? 28'h2 : 28'h1));
`else
            chk("t4_fixed_d", CW'(mem_addr), CW'(28'h2));
`endif
            prev_addr = mem_addr;
            tick();
            mem_ready = 1'b1;
            mid("t4_ready");
            tick();
            mem_ready = 1'b0;
        end
        {i_read, d_read} = '0;
        mid("t4_end");
        tick();
        // Randomized traffic, requests held until their own ready.
        for (int c = 0; c < 400; c++) begin
            if (done_i) {i_read, i_write} = '0;
            if (done_d) {d_read, d_write} = '0;
            if (!(i_read | i_write) && !done_i && $urandom_range(2) == 0) begin
                {i_read, i_write} = 2'($urandom_range(3, 1));
                i_addr = ADDR_W'($urandom);
                i_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!(d_read | d_write) && !done_d && $urandom_range(2) == 0) begin
                {d_read, d_write} = 2'($urandom_range(3, 1));
                d_addr = ADDR_W'($urandom);
                d_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            if (owner != 0) begin
                mem_ready = lat == 0;
                lat = (lat == 0) ? int'($urandom_range(4)) : lat - 1;
            end else begin
                mem_ready = $urandom_range(5) == 0;
            end
            mid("rand");
            tick();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
